// File: rtl/mul_div_unit_if.sv
// Handshake and register bus between pipeline control and the multiply/divide unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_din;
    logic [WIDTH-1:0] b_din;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wr_din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a_din, b_din, mthi, mtlo, wr_din,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a_din, b_din, mthi, mtlo, wr_din,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, with architectural HI/LO.
// Operands are reduced to magnitudes at launch; signs are re-applied in the FIX cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               neg_res;    // product / quotient must be negated
    logic               neg_rem;    // remainder must be negated (dividend was negative)
    logic               div_zero;
    logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_hi;     // product high half / partial remainder
    logic [WIDTH-1:0]   acc_lo;     // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               signed_op;
    logic               last_iter;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   acc_hi_next;
    logic [WIDTH-1:0]   acc_lo_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // op[0]=0 selects the signed variants (MULT, DIV).
    assign signed_op = ~bus.op[0];
    assign a_mag     = (signed_op && bus.a_din[WIDTH-1]) ? -bus.a_din : bus.a_din;
    assign b_mag     = (signed_op && bus.b_din[WIDTH-1]) ? -bus.b_din : bus.b_din;
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    // Sign fix-up; a zero divisor forces an all-ones quotient, while the remainder
    // path naturally reproduces the original dividend.
    assign prod_fixed = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fixed  = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
    assign rem_fixed  = neg_rem ? -acc_hi : acc_hi;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode: IDLE -> CALC -> FIX -> IDLE.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One shift-add or restoring-divide step on the accumulator pair.
    always_comb begin
        mul_sum     = '0;
        div_trial   = '0;
        acc_hi_next = acc_hi;
        acc_lo_next = acc_lo;
        if (is_div) begin
            // Partial remainder never exceeds the bits shifted in so far, so bit WIDTH is a true borrow.
            div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};
            if (!div_trial[WIDTH]) begin
                acc_hi_next = div_trial[WIDTH-1:0];
                acc_lo_next = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_next = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                acc_lo_next = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
            acc_hi_next = mul_sum[WIDTH:1];
            acc_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Datapath, HI/LO and handshake registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
        if (rst) begin
            count    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count    <= '0;
                        busy_q   <= 1'b1;
                        is_div   <= bus.op[1];
                        neg_res  <= signed_op && (bus.a_din[WIDTH-1] ^ bus.b_din[WIDTH-1]);
                        neg_rem  <= signed_op && bus.a_din[WIDTH-1];
                        div_zero <= bus.op[1] && (bus.b_din == '0);
                        acc_hi   <= '0;
                        acc_lo   <= bus.op[1] ? a_mag : b_mag;
                        opnd     <= bus.op[1] ? b_mag : a_mag;
                    end else begin
                        if (bus.mthi) hi_q <= bus.wr_din;
                        if (bus.mtlo) lo_q <= bus.wr_din;
                    end
                end
                CALC: begin
                    count  <= count + 1'b1;
                    acc_hi <= acc_hi_next;
                    acc_lo <= acc_lo_next;
                end
                FIX: begin
                    if (is_div) begin
                        hi_q <= rem_fixed;
                        lo_q <= quo_fixed;
                    end else begin
                        {hi_q, lo_q} <= prod_fixed;
                    end
                    count  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
